regi_wb_arbiter: RTL and testbench

//  Write-back arbiter directly upstream of the integer register bank write port.

---
 rtl/regi_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_regi_wb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regi_wb_arbiter.sv
// regi_wb_arbiter
//   Write-back arbiter in front of the integer register bank write port.
//   Executor results (never stalled) always win the port; memaccess load
//   returns are buffered in a small in-order FIFO and drained whenever the
//   executor is idle or writing x0. If buffered loads keep losing, an
//   advisory hold request is raised towards the executor.
//
//   Optional feature: define RIVER_WB_BYPASS_EN to let an accepted load
//   return skip the FIFO when the FIFO is empty and the executor does not
//   take the port (latency 1 instead of 2).
//
// Ports
//   i_clk, i_nrst                 clock, active-low reset
//   i_e_wena/waddr/wtag/wdata     executor write request (no back-pressure)
//   o_e_hold                      registered stall request to the executor
//   i_m_valid, o_m_ready          load-return handshake
//   i_m_waddr/wtag/wdata          load-return payload
//   o_wena/waddr/wtag/wdata       registered bank write port
//   o_inorder                     1 = write came from the load path
//   o_fifo_cnt                    FIFO occupancy (debug/tracer)
module regi_wb_arbiter #(
  parameter logic async_reset  = 1'b1,
  parameter int   FIFO_DEPTH   = 4,
  parameter int   STARVE_LIMIT = 8
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_e_wena,
  input  logic [5:0]                  i_e_waddr,
  input  logic [2:0]                  i_e_wtag,
  input  logic [63:0]                 i_e_wdata,
  output logic                        o_e_hold,
  input  logic                        i_m_valid,
  output logic                        o_m_ready,
  input  logic [5:0]                  i_m_waddr,
  input  logic [2:0]                  i_m_wtag,
  input  logic [63:0]                 i_m_wdata,
  output logic                        o_wena,
  output logic [5:0]                  o_waddr,
  output logic [2:0]                  o_wtag,
  output logic [63:0]                 o_wdata,
  output logic                        o_inorder,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 6 + 3 + 64;

  typedef struct packed {
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          hold;
    logic          wena;
    logic [5:0]    waddr;
    logic [2:0]    wtag;
    logic [63:0]   wdata;
    logic          inorder;
  } regs_t;

  localparam regs_t R_RESET = '0;

  regs_t r, rin;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic          fifo_empty;
  logic          m_ready;
  logic          m_keep;
  logic          e_win;
  logic          push;
  logic          pop;

  always_comb begin
    rin        = r;
    pop        = 1'b0;
    fifo_empty = (r.cnt == '0);
    // Ready comes only from the registered count: a pop in the same cycle
    // does not reopen a full FIFO.
    m_ready    = (r.cnt != CW'(FIFO_DEPTH));
    // Loads to x0 complete the handshake but are never written.
    m_keep     = i_m_valid & m_ready & (i_m_waddr != '0);
    e_win      = i_e_wena & (i_e_waddr != '0);
    head       = mem[r.rd_ptr];
    push       = m_keep;

    if (e_win) begin
      rin.wena    = 1'b1;
      rin.waddr   = i_e_waddr;
      rin.wtag    = i_e_wtag;
      rin.wdata   = i_e_wdata;
      rin.inorder = 1'b0;
      if (!fifo_empty && (r.starve != SW'(STARVE_LIMIT))) begin
        rin.starve = r.starve + 1'b1;
      end
    end else if (!fifo_empty) begin
      rin.wena    = 1'b1;
      rin.waddr   = head[EW-1 -: 6];
      rin.wtag    = head[63+3 -: 3];
      rin.wdata   = head[63:0];
      rin.inorder = 1'b1;
      rin.starve  = '0;
      pop         = 1'b1;
    end
`ifdef RIVER_WB_BYPASS_EN
    else if (m_keep) begin
      rin.wena    = 1'b1;
      rin.waddr   = i_m_waddr;
      rin.wtag    = i_m_wtag;
      rin.wdata   = i_m_wdata;
      rin.inorder = 1'b1;
      push        = 1'b0;
    end
`endif
    else begin
      rin.wena = 1'b0;
    end

    if (push) begin
      rin.wr_ptr = r.wr_ptr + 1'b1;
    end
    if (pop) begin
      rin.rd_ptr = r.rd_ptr + 1'b1;
    end
    if (push && !pop) begin
      rin.cnt = r.cnt + 1'b1;
    end else if (pop && !push) begin
      rin.cnt = r.cnt - 1'b1;
    end

    rin.hold = (rin.starve == SW'(STARVE_LIMIT));
  end

  generate
    if (async_reset) begin : g_async_rst
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
          r <= R_RESET;
        end else begin
          r <= rin;
        end
      end
    end else begin : g_sync_rst
      always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
          r <= R_RESET;
        end else begin
          r <= rin;
        end
      end
    end
  endgenerate

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[r.wr_ptr] <= {i_m_waddr, i_m_wtag, i_m_wdata};
    end
  end

  assign o_m_ready  = m_ready;
  assign o_e_hold   = r.hold;
  assign o_wena     = r.wena;
  assign o_waddr    = r.waddr;
  assign o_wtag     = r.wtag;
  assign o_wdata    = r.wdata;
  assign o_inorder  = r.inorder;
  assign o_fifo_cnt = r.cnt;

endmodule

// File: tb/tb_regi_wb_arbiter.sv
module tb_regi_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_e_wena = 1'b0;
  logic [5:0]  i_e_waddr = '0;
  logic [2:0]  i_e_wtag = '0;
  logic [63:0] i_e_wdata = '0;
  logic        o_e_hold;
  logic        i_m_valid = 1'b0;
  logic        o_m_ready;
  logic [5:0]  i_m_waddr = '0;
  logic [2:0]  i_m_wtag = '0;
  logic [63:0] i_m_wdata = '0;
  logic        o_wena;
  logic [5:0]  o_waddr;
  logic [2:0]  o_wtag;
  logic [63:0] o_wdata;
  logic        o_inorder;
  logic [2:0]  o_fifo_cnt;

  regi_wb_arbiter dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_e_wena(i_e_wena), .i_e_waddr(i_e_waddr), .i_e_wtag(i_e_wtag), .i_e_wdata(i_e_wdata),
    .o_e_hold(o_e_hold),
    .i_m_valid(i_m_valid), .o_m_ready(o_m_ready),
    .i_m_waddr(i_m_waddr), .i_m_wtag(i_m_wtag), .i_m_wdata(i_m_wdata),
    .o_wena(o_wena), .o_waddr(o_waddr), .o_wtag(o_wtag), .o_wdata(o_wdata),
    .o_inorder(o_inorder), .o_fifo_cnt(o_fifo_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  a;
    logic [2:0]  t;
    logic [63:0] d;
  } ent_t;

  // Reference model: a queue of pending loads plus the expected port state.
  ent_t        q[$];
  logic        m_wena, m_inorder, m_hold;
  logic [5:0]  m_waddr;
  logic [2:0]  m_wtag;
  logic [63:0] m_wdata;
  int          starve;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wena = 0; m_inorder = 0; m_hold = 0;
    m_waddr = '0; m_wtag = '0; m_wdata = '0;
    starve = 0;
  endtask

  task automatic check_all();
    chk("wena", o_wena, m_wena);
    chk("waddr", o_waddr, m_waddr);
    chk("wtag", o_wtag, m_wtag);
    chk("wdata", o_wdata, m_wdata);
    chk("inorder", o_inorder, m_inorder);
    chk("hold", o_e_hold, m_hold);
    chk("fifo_cnt", o_fifo_cnt, 64'(q.size()));
    chk("m_ready", o_m_ready, 64'(q.size() != DEPTH));
  endtask

  task automatic model_step();
    bit   was_empty, acc, e_win, byp;
    ent_t e;
    was_empty = (q.size() == 0);
    acc       = i_m_valid && (q.size() != DEPTH);
    e_win     = i_e_wena && (i_e_waddr != 0);
    byp       = 0;
    if (e_win) begin
      m_wena = 1; m_waddr = i_e_waddr; m_wtag = i_e_wtag; m_wdata = i_e_wdata; m_inorder = 0;
      if (!was_empty && starve < LIMIT) starve++;
    end else if (!was_empty) begin
      e = q.pop_front();
      m_wena = 1; m_waddr = e.a; m_wtag = e.t; m_wdata = e.d; m_inorder = 1;
      starve = 0;
    end else begin
`ifdef RIVER_WB_BYPASS_EN
      if (acc && i_m_waddr != 0) begin
        byp = 1;
        m_wena = 1; m_waddr = i_m_waddr; m_wtag = i_m_wtag; m_wdata = i_m_wdata; m_inorder = 1;
      end else begin
        m_wena = 0;
      end
`else
      m_wena = 0;
`endif
    end
    if (acc && i_m_waddr != 0 && !byp) begin
      e.a = i_m_waddr; e.t = i_m_wtag; e.d = i_m_wdata;
      q.push_back(e);
    end
    m_hold = (starve == LIMIT);
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model,
  // return 1 time unit after the rising edge.
  task automatic cycle(input logic ev, input logic [5:0] ea, input logic [2:0] et,
                       input logic [63:0] ed, input logic mv, input logic [5:0] ma,
                       input logic [2:0] mt, input logic [63:0] md);
    i_e_wena = ev; i_e_waddr = ea; i_e_wtag = et; i_e_wdata = ed;
    i_m_valid = mv; i_m_waddr = ma; i_m_wtag = mt; i_m_wdata = md;
    @(negedge i_clk);
    check_all();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_phase(input int n, input int e_pct, input int m_pct);
    logic [5:0] ea, ma;
    for (int i = 0; i < n; i++) begin
      ea = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      ma = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      cycle($urandom_range(0, 99) < e_pct, ea, 3'($urandom), {$urandom, $urandom},
            $urandom_range(0, 99) < m_pct, ma, 3'($urandom), {$urandom, $urandom});
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_wena", o_wena, 0);
    chk("rst_cnt", o_fifo_cnt, 0);
    chk("rst_ready", o_m_ready, 1);
    chk("rst_hold", o_e_hold, 0);
    i_nrst = 1'b1;

    // T1: reset with three loads buffered
    for (int i = 0; i < 3; i++) cycle(1, 6'd5, 3'd0, 64'h11, 1, 6'd10, 3'(i), 64'(i));
    chk("t1_cnt_pre", o_fifo_cnt, 3);
    i_nrst = 1'b0;
    #1;
    chk("t1_wena", o_wena, 0);
    chk("t1_cnt", o_fifo_cnt, 0);
    chk("t1_ready", o_m_ready, 1);
    chk("t1_hold", o_e_hold, 0);
    model_reset();
    i_e_wena = 0; i_m_valid = 0;
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(posedge i_clk);
    #1;

    // T2: load-only stream to x10
    cycle(0, 0, 0, 0, 1, 6'd10, 3'd1, 64'h100);
`ifdef RIVER_WB_BYPASS_EN
    chk("t2_lat1_wena", o_wena, 1);
    chk("t2_lat1_cnt", o_fifo_cnt, 0);
`else
    chk("t2_lat2_wena", o_wena, 0);
    chk("t2_lat2_cnt", o_fifo_cnt, 1);
`endif
    for (int i = 2; i <= 5; i++) cycle(0, 0, 0, 0, 1, 6'd10, 3'(i), 64'(256 + i));
    idle(2);

    // T3: executor and FIFO head collide
    cycle(1, 6'd1, 3'd0, 64'h1, 1, 6'd7, 3'd2, 64'h77);
    cycle(1, 6'd5, 3'd3, 64'hAA, 0, 0, 0, 0);
    chk("t3_exec_addr", o_waddr, 5);
    chk("t3_exec_inorder", o_inorder, 0);
    chk("t3_exec_data", o_wdata, 64'hAA);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_load_addr", o_waddr, 7);
    chk("t3_load_inorder", o_inorder, 1);
    idle(1);

    // T4: fill while executor is busy
    for (int i = 0; i < 5; i++) begin
      cycle(1, 6'd2, 3'd0, 64'(i), 1, 6'd12, 3'(i), 64'(i + 32));
      if (i == 3) chk("t4_ready_full", o_m_ready, 0);
    end
    chk("t4_cnt_full", o_fifo_cnt, 4);
    chk("t4_ready_pop_cycle", o_m_ready, 0);
    cycle(0, 0, 0, 0, 1, 6'd13, 3'd5, 64'h55);
    chk("t4_ready_after_pop", o_m_ready, 1);
    chk("t4_cnt_after_pop", o_fifo_cnt, 3);
    idle(5);

    // T5: starvation
    cycle(1, 6'd4, 3'd0, 64'h4, 1, 6'd9, 3'd1, 64'h99);
    for (int i = 0; i < LIMIT; i++) begin
      cycle(1, 6'd4, 3'(i), 64'(i), 0, 0, 0, 0);
      chk("t5_hold", o_e_hold, (i == LIMIT - 1) ? 1 : 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_hold_clear", o_e_hold, 0);
    chk("t5_pop_addr", o_waddr, 9);
    idle(1);

    // T6: x0 handling on both paths
    cycle(1, 6'd1, 3'd0, 64'h1, 1, 6'd3, 3'd4, 64'h33);
    cycle(1, 6'd0, 3'd0, 64'hDEAD, 0, 0, 0, 0);
    chk("t6_head_wena", o_wena, 1);
    chk("t6_head_addr", o_waddr, 3);
    chk("t6_head_inorder", o_inorder, 1);
    cycle(0, 0, 0, 0, 1, 6'd0, 3'd1, 64'hBEEF);
    chk("t6_x0_load_wena", o_wena, 0);
    chk("t6_x0_load_cnt", o_fifo_cnt, 0);

    // Randomized traffic against the model
    rand_phase(1500, 40, 50);
    rand_phase(800, 90, 60);
    rand_phase(800, 20, 80);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
